// File: rtl/seg7_scan_mux_pkg.sv
// Segment patterns {g,f,e,d,c,b,a} (active high) and width helpers shared by display blocks.
// Constants only; no latency, no backpressure.
package seg7_scan_mux_pkg;

    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_A   = 7'h77;
    localparam logic [6:0] SEG_B   = 7'h7C;
    localparam logic [6:0] SEG_C   = 7'h39;
    localparam logic [6:0] SEG_D   = 7'h5E;
    localparam logic [6:0] SEG_E   = 7'h79;
    localparam logic [6:0] SEG_F   = 7'h71;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Counter width for values 0..n-1, never below one bit.
    function automatic int clog2w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg7_scan_mux_hex_decode.sv
// Hex nibble to active-high 7-segment pattern {g,f,e,d,c,b,a}.
// Combinational, zero latency, no backpressure.
module seg7_hex_decode
    import seg7_scan_mux_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_0;
        case (i_nib)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'hA: o_seg = SEG_A;
            4'hB: o_seg = SEG_B;
            4'hC: o_seg = SEG_C;
            4'hD: o_seg = SEG_D;
            4'hE: o_seg = SEG_E;
            default: o_seg = SEG_F;
        endcase
    end

endmodule

// File: rtl/seg7_scan_mux.sv
// Scanned common-anode 7-segment driver; one digit per scan_clk rise, frame-coherent updates.
// scan_clk rise -> pins change after 4 clk (+BLANK_CYCLES to light); no backpressure, load always accepted.
module seg7_scan_mux
    import seg7_scan_mux_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int BLANK_CYCLES = 16,
    parameter bit LZ_BLANK     = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scan_clk,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    output logic [DIGITS-1:0]     an_n,
    output logic [6:0]            seg_n,
    output logic                  dp_n
);

    localparam int IDX_W = clog2w(DIGITS);
    localparam int BC_W  = clog2w(BLANK_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DIGITS - 1);
    localparam logic [BC_W-1:0]  BLANK_INIT = BC_W'(BLANK_CYCLES);

    logic                r_s1, r_s2, r_s3;
    logic [IDX_W-1:0]    r_idx;
    logic [BC_W-1:0]     r_blank_cnt;
    logic [4*DIGITS-1:0] r_shadow_dat, r_frame_dat;
    logic [DIGITS-1:0]   r_shadow_dp, r_frame_dp;
    logic                r_pending;

    logic                w_tick;
    logic                w_wrap;
    logic [IDX_W+1:0]    w_shamt;
    logic [4*DIGITS-1:0] w_upper;
    logic                w_supp;
    logic [6:0]          w_seg;
    logic [DIGITS-1:0]   w_onehot;

    assign w_tick   = r_s2 & ~r_s3;
    assign w_wrap   = w_tick && (r_idx == LAST_IDX);
    // Nibbles from the current digit upward; the low nibble is the digit itself.
    assign w_shamt  = {r_idx, 2'b00};
    assign w_upper  = r_frame_dat >> w_shamt;
    assign w_supp   = LZ_BLANK && (r_idx != '0) && (w_upper == '0);
    assign w_onehot = DIGITS'(1) << r_idx;

    seg7_hex_decode u_dec (
        .i_nib (w_upper[3:0]),
        .o_seg (w_seg)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= scan_clk;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_blank_cnt <= '0;
        end else if (w_tick) begin
            r_idx       <= w_wrap ? '0 : r_idx + 1'b1;
            r_blank_cnt <= BLANK_INIT;
        end else if (r_blank_cnt != '0) begin
            r_blank_cnt <= r_blank_cnt - 1'b1;
        end
    end

    // A load on the commit tick lands in shadow after the old shadow has moved to frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow_dat <= '0;
            r_shadow_dp  <= '0;
            r_frame_dat  <= '0;
            r_frame_dp   <= '0;
            r_pending    <= 1'b0;
        end else begin
            if (w_wrap && r_pending) begin
                r_frame_dat <= r_shadow_dat;
                r_frame_dp  <= r_shadow_dp;
                r_pending   <= 1'b0;
            end
            if (load) begin
                r_shadow_dat <= data;
                r_shadow_dp  <= dp;
                r_pending    <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n  <= '1;
            seg_n <= SEG_OFF;
            dp_n  <= 1'b1;
        end else if ((r_blank_cnt != '0) || w_supp) begin
            an_n  <= '1;
            seg_n <= SEG_OFF;
            dp_n  <= 1'b1;
        end else begin
            an_n  <= ~w_onehot;
            seg_n <= ~w_seg;
            dp_n  <= ~r_frame_dp[r_idx];
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: default, leading-zero-blank and no-blanking instances share stimulus.
// A frame/shadow model driven by scan-edge and load events predicts every pin value.
module tb_seg7_scan_mux;

    localparam int ND = 4;
    localparam logic [11:0] OFF = {4'hF, 7'h7F, 1'b1};
    localparam logic [6:0] SEG_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scan_clk = 1'b0;
    logic        load = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  an0, an1, an2;
    logic [6:0]  seg0, seg1, seg2;
    logic        dpn0, dpn1, dpn2;

    int total = 0;
    int bad = 0;

    int          m_idx;
    logic [15:0] m_sh_d, m_fr_d;
    logic [3:0]  m_sh_p, m_fr_p;
    bit          m_pend;
    logic [3:0]  lz_low;

    always #5 clk = ~clk;

    seg7_scan_mux #(.DIGITS(ND), .BLANK_CYCLES(16), .LZ_BLANK(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .scan_clk(scan_clk), .load(load), .data(data), .dp(dp),
        .an_n(an0), .seg_n(seg0), .dp_n(dpn0));
    seg7_scan_mux #(.DIGITS(ND), .BLANK_CYCLES(16), .LZ_BLANK(1'b1)) dut_lz (
        .clk(clk), .rst_n(rst_n), .scan_clk(scan_clk), .load(load), .data(data), .dp(dp),
        .an_n(an1), .seg_n(seg1), .dp_n(dpn1));
    seg7_scan_mux #(.DIGITS(ND), .BLANK_CYCLES(0), .LZ_BLANK(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n), .scan_clk(scan_clk), .load(load), .data(data), .dp(dp),
        .an_n(an2), .seg_n(seg2), .dp_n(dpn2));

    // Pins for a lit digit: {an_n, seg_n, dp_n}; leading zeros counted numerically.
    function automatic logic [11:0] render(input int idx, input logic [15:0] fd,
                                           input logic [3:0] fp, input bit lz);
        int   upper;
        logic [3:0] an;
        upper = int'(fd) / (1 << (4 * idx));
        if (lz && idx > 0 && upper == 0) return OFF;
        an = 4'(15 - (1 << idx));
        return {an, 7'h7F ^ SEG_TAB[upper % 16], ~fp[idx]};
    endfunction

    function automatic logic [11:0] observed(input int j);
        if (j == 0) return {an0, seg0, dpn0};
        if (j == 1) return {an1, seg1, dpn1};
        return {an2, seg2, dpn2};
    endfunction

    task automatic model_reset();
        m_idx = 0; m_sh_d = '0; m_fr_d = '0; m_sh_p = '0; m_fr_p = '0; m_pend = 1'b0;
    endtask

    task automatic model_scan();
        if (m_idx == ND - 1) begin
            if (m_pend) begin
                m_fr_d = m_sh_d;
                m_fr_p = m_sh_p;
                m_pend = 1'b0;
            end
            m_idx = 0;
        end else begin
            m_idx = m_idx + 1;
        end
    endtask

    task automatic model_load(input logic [15:0] d, input logic [3:0] p);
        m_sh_d = d;
        m_sh_p = p;
        m_pend = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        logic [11:0] e;
        load = 1'b1; data = d; dp = p;
        step();
        load = 1'b0;
        model_load(d, p);
        e = render(m_idx, m_fr_d, m_fr_p, 1'b0);
        total++;
        if (observed(0) !== e) begin
            bad++;
            $display("FAIL load_no_tear: got %h want %h", observed(0), e);
        end
    endtask

    // One scan_clk pulse; optionally raises load in the same clk as the resulting tick.
    task automatic do_scan(input bit ld, input logic [15:0] d, input logic [3:0] p);
        logic [11:0] old_e [3];
        logic [11:0] new_e [3];
        logic [11:0] e;
        int offc;
        int lo;
        for (int j = 0; j < 3; j++) old_e[j] = render(m_idx, m_fr_d, m_fr_p, j == 1);
        model_scan();
        for (int j = 0; j < 3; j++) new_e[j] = render(m_idx, m_fr_d, m_fr_p, j == 1);
        scan_clk = 1'b1;
        offc = 0;
        for (int k = 1; k <= 24; k++) begin
            if (ld && k == 3) begin
                load = 1'b1; data = d; dp = p;
            end
            step();
            if (ld && k == 3) begin
                load = 1'b0;
                model_load(d, p);
            end
            lz_low = lz_low | ~an1;
            if (observed(0) === OFF) offc++;
            for (int j = 0; j < 3; j++) begin
                if (k <= 3) e = old_e[j];
                else if (j != 2 && k <= 19) e = OFF;
                else e = new_e[j];
                total++;
                if (observed(j) !== e) begin
                    bad++;
                    $display("FAIL scan_pins inst=%0d k=%0d idx=%0d: got %h want %h",
                             j, k, m_idx, observed(j), e);
                end
            end
        end
        total++;
        if (offc !== 16) begin
            bad++;
            $display("FAIL blank_len: got %0d want 16", offc);
        end
        scan_clk = 1'b0;
        lo = $urandom_range(3, 6);
        for (int k = 0; k < lo; k++) step();
    endtask

    task automatic test_reset();
        logic [11:0] e;
        rst_n = 1'b0;
        model_reset();
        repeat (3) step();
        for (int j = 0; j < 3; j++) begin
            total++;
            if (observed(j) !== OFF) begin
                bad++;
                $display("FAIL reset_hold inst=%0d: got %h want %h", j, observed(j), OFF);
            end
        end
        rst_n = 1'b1;
        repeat (3) step();
        e = {4'hE, 7'h7F ^ 7'h3F, 1'b1};
        for (int j = 0; j < 3; j++) begin
            total++;
            if (observed(j) !== e) begin
                bad++;
                $display("FAIL reset_release inst=%0d: got %h want %h", j, observed(j), e);
            end
        end
    endtask

    task automatic test_scan();
        logic [3:0] exp_an [5];
        logic [6:0] exp_pat [5];
        exp_an  = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
        exp_pat = '{7'h71, 7'h77, 7'h5B, 7'h06, 7'h71};
        do_load(16'h12AF, 4'h0);
        for (int i = 0; i < ND && m_idx != ND - 1; i++) do_scan(1'b0, '0, '0);
        for (int i = 0; i < 5; i++) begin
            do_scan(1'b0, '0, '0);
            total++;
            if (an0 !== exp_an[i] || seg0 !== (7'h7F ^ exp_pat[i])) begin
                bad++;
                $display("FAIL scan_seq step=%0d: got an=%h seg=%h want an=%h seg=%h",
                         i, an0, seg0, exp_an[i], 7'h7F ^ exp_pat[i]);
            end
        end
    endtask

    task automatic test_frame_coherence();
        for (int i = 0; i < ND && m_idx != 2; i++) do_scan(1'b0, '0, '0);
        do_load(16'h0000, 4'h0);
        do_scan(1'b0, '0, '0);
        total++;
        if (an0 !== 4'h7 || seg0 !== (7'h7F ^ 7'h06)) begin
            bad++;
            $display("FAIL coherent_old: got an=%h seg=%h want an=7 seg=%h", an0, seg0, 7'h7F ^ 7'h06);
        end
        do_scan(1'b0, '0, '0);
        total++;
        if (an0 !== 4'hE || seg0 !== (7'h7F ^ 7'h3F)) begin
            bad++;
            $display("FAIL coherent_new: got an=%h seg=%h want an=e seg=%h", an0, seg0, 7'h7F ^ 7'h3F);
        end
    endtask

    task automatic test_load_on_commit();
        logic [15:0] x;
        logic [6:0]  want;
        x = 16'($urandom);
        for (int i = 0; i < ND && m_idx != ND - 1; i++) do_scan(1'b0, '0, '0);
        do_load(x, 4'($urandom));
        do_scan(1'b1, 16'h5555, 4'h0);
        for (int i = 0; i < ND; i++) begin
            want = 7'h7F ^ SEG_TAB[(int'(x) >> (4 * i)) % 16];
            total++;
            if (seg0 !== want) begin
                bad++;
                $display("FAIL commit_old digit=%0d: got %h want %h", i, seg0, want);
            end
            do_scan(1'b0, '0, '0);
        end
        total++;
        if (an0 !== 4'hE || seg0 !== (7'h7F ^ 7'h6D)) begin
            bad++;
            $display("FAIL commit_next: got an=%h seg=%h want an=e seg=%h", an0, seg0, 7'h7F ^ 7'h6D);
        end
    endtask

    task automatic test_leading_zero();
        do_load(16'h0070, 4'($urandom));
        for (int i = 0; i < ND; i++) do_scan(1'b0, '0, '0);
        lz_low = '0;
        for (int i = 0; i < ND; i++) do_scan(1'b0, '0, '0);
        total++;
        if (lz_low !== 4'b0011) begin
            bad++;
            $display("FAIL lz_0070 lit digits: got %b want 0011", lz_low);
        end
        do_load(16'h0000, 4'($urandom));
        for (int i = 0; i < ND; i++) do_scan(1'b0, '0, '0);
        lz_low = '0;
        for (int i = 0; i < ND; i++) do_scan(1'b0, '0, '0);
        total++;
        if (lz_low !== 4'b0001) begin
            bad++;
            $display("FAIL lz_0000 lit digits: got %b want 0001", lz_low);
        end
    endtask

    task automatic test_random();
        int r;
        for (int i = 0; i < 30; i++) begin
            r = $urandom_range(0, 3);
            if (r == 0) do_load(16'($urandom), 4'($urandom));
            else if (r == 1) do_scan(1'b1, 16'($urandom), 4'($urandom));
            else do_scan(1'b0, '0, '0);
        end
    endtask

    task automatic test_async_reset();
        logic [11:0] e;
        do_load(16'h9C3B, 4'hA);
        for (int i = 0; i < 2 * ND && !(m_idx == ND - 1 && !m_pend); i++) do_scan(1'b0, '0, '0);
        total++;
        if (an2 !== 4'h7) begin
            bad++;
            $display("FAIL pre_reset_idx3: got an=%h want 7", an2);
        end
        #2 rst_n = 1'b0;
        #1;
        for (int j = 0; j < 3; j++) begin
            total++;
            if (observed(j) !== OFF) begin
                bad++;
                $display("FAIL async_reset inst=%0d: got %h want %h", j, observed(j), OFF);
            end
        end
        model_reset();
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();
        e = render(0, 16'h0000, 4'h0, 1'b0);
        total++;
        if (observed(2) !== e) begin
            bad++;
            $display("FAIL reset_resume0: got %h want %h", observed(2), e);
        end
        do_scan(1'b0, '0, '0);
        total++;
        if (an2 !== 4'hD) begin
            bad++;
            $display("FAIL reset_resume1: got an=%h want d", an2);
        end
    endtask

    initial begin
        lz_low = '0;
        model_reset();
        test_reset();
        test_scan();
        test_frame_coherence();
        test_load_on_commit();
        test_leading_zero();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
